div12_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational divide-by-12 unit (`div_by_12`) between `NUM_REQ` requesters. Each requester presents a 6-bit numerator with a valid/ready handshake. The block grants at most one requester per cycle, registers the quotient and remainder with the winner's ID, and holds the result until the consumer accepts it. It sits between note and octave producers and the tone/octave datapath that consumes (quotient, remainder) pairs.

---
 rtl/div12_pkg.sv | 12 +
 rtl/div_by_12.sv | 11 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/div12_arbiter.sv | 120 ++++++++++++
 tb/tb_div12_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/div12_pkg.sv
// Shared constants and response type for the divide-by-12 arbiter slice.
package div12_pkg;
    localparam int NUMER_W = 6;
    localparam int QUOT_W  = 3;
    localparam int REM_W   = 4;
    localparam int DIVISOR = 12;

    typedef struct packed {
        logic [QUOT_W-1:0] quotient;
        logic [REM_W-1:0]  remain;
    } div12_rsp_t;
endpackage

// File: rtl/div_by_12.sv
// Combinational divide-by-12 of a 6-bit numerator into (quotient, remainder).
module div_by_12
    import div12_pkg::*;
(
    input  logic [NUMER_W-1:0] numer,
    output div12_rsp_t         rsp
);
    // 63/12 = 5 and x%12 < 12, so truncating to QUOT_W/REM_W loses nothing.
    assign rsp.quotient = QUOT_W'(numer / NUMER_W'(DIVISOR));
    assign rsp.remain   = REM_W'(numer % NUMER_W'(DIVISOR));
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx,
    output logic               any
);
    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        if (en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                j = int'(ptr) + k;
                if (j >= NUM_REQ) j = j - NUM_REQ;
                if (!any && req[j]) begin
                    any    = 1'b1;
                    gnt[j] = 1'b1;
                    idx    = ID_W'(j);
                end
            end
        end
    end
endmodule

// File: rtl/div12_arbiter.sv
// Round-robin sharing of one div_by_12 among NUM_REQ requesters with a one-entry
// response register. Optional counters via DIV12_ARB_STATS_EN.
module div12_arbiter
    import div12_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*NUMER_W-1:0] req_numer,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [QUOT_W-1:0]          rsp_quotient,
    output logic [REM_W-1:0]           rsp_remain
`ifdef DIV12_ARB_STATS_EN
    ,
    output logic [15:0]                stat_grants,
    output logic [15:0]                stat_stalls
`endif
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    div12_rsp_t        rsp_q, rsp_d;

    logic              slot_avail;
    logic              arb_en;
    logic              accept;
    logic [ID_W-1:0]   gnt_idx;
    logic [NUMER_W-1:0] sel_numer;
    div12_rsp_t        div_rsp;

    // A full slot still accepts when the consumer drains it this cycle.
    assign slot_avail = (state_q == EMPTY) || rsp_ready;
    assign arb_en     = slot_avail && rst_n;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .en  (arb_en),
        .gnt (req_ready),
        .idx (gnt_idx),
        .any (accept)
    );

    assign sel_numer = req_numer[gnt_idx*NUMER_W +: NUMER_W];

    div_by_12 u_div (
        .numer (sel_numer),
        .rsp   (div_rsp)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        rsp_id_d = rsp_id_q;
        rsp_d    = rsp_q;
        if (accept) begin
            state_d  = FULL;
            rsp_d    = div_rsp;
            rsp_id_d = gnt_idx;
            rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
        end else if (state_q == FULL && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            rr_ptr_q <= '0;
            rsp_id_q <= '0;
            rsp_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            rsp_id_q <= rsp_id_d;
            rsp_q    <= rsp_d;
        end
    end

    assign rsp_valid    = (state_q == FULL);
    assign rsp_id       = rsp_id_q;
    assign rsp_quotient = rsp_q.quotient;
    assign rsp_remain   = rsp_q.remain;

`ifdef DIV12_ARB_STATS_EN
    logic [15:0] stat_grants_q, stat_grants_d;
    logic [15:0] stat_stalls_q, stat_stalls_d;
    logic        stall;

    assign stall = (state_q == FULL) && !rsp_ready && (|req_valid);

    always_comb begin
        stat_grants_d = stat_grants_q;
        stat_stalls_d = stat_stalls_q;
        if (accept && stat_grants_q != 16'hFFFF) stat_grants_d = stat_grants_q + 16'd1;
        if (stall && stat_stalls_q != 16'hFFFF) stat_stalls_d = stat_stalls_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_grants_q <= '0;
            stat_stalls_q <= '0;
        end else begin
            stat_grants_q <= stat_grants_d;
            stat_stalls_q <= stat_stalls_d;
        end
    end

    assign stat_grants = stat_grants_q;
    assign stat_stalls = stat_stalls_q;
`endif
endmodule

// File: tb/tb_div12_arbiter.sv
// Bench for div12_arbiter: directed steps plus random traffic against a queue-free
// reference model (plain / and % with a search from the round-robin pointer).
module tb_div12_arbiter;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N*6-1:0] req_numer;
    logic [N-1:0]  req_ready;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [2:0]    rsp_quotient;
    logic [3:0]    rsp_remain;
`ifdef DIV12_ARB_STATS_EN
    logic [15:0]   stat_grants;
    logic [15:0]   stat_stalls;
`endif

    always #5 clk = ~clk;

    div12_arbiter #(.NUM_REQ(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_numer    (req_numer),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_quotient (rsp_quotient),
        .rsp_remain   (rsp_remain)
`ifdef DIV12_ARB_STATS_EN
        ,
        .stat_grants  (stat_grants),
        .stat_stalls  (stat_stalls)
`endif
    );

    int n_asrt = 0;
    int n_fail = 0;
    int m_ptr = 0;
    bit m_v = 0;
    int m_id = 0, m_q = 0, m_r = 0;
    int m_grants = 0, m_stalls = 0;
    int exp_w = -1;
    bit auto_drop = 1;
    int sv_id, sv_q, sv_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_numer(input int i, input int v);
        req_numer[i*6 +: 6] = 6'(v);
    endtask

    // Predict the grant from current inputs and compare all outputs.
    task automatic eval();
        int j;
        #1;
        exp_w = -1;
        if (rst_n && (!m_v || rsp_ready)) begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (exp_w < 0 && req_valid[j]) exp_w = j;
            end
        end
        chk("req_ready", 32'(req_ready), (exp_w < 0) ? 32'd0 : (32'd1 << exp_w));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_v));
        if (m_v) begin
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
            chk("rsp_quotient", 32'(rsp_quotient), 32'(m_q));
            chk("rsp_remain", 32'(rsp_remain), 32'(m_r));
        end
    endtask

    task automatic tick();
        int n;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_v = 0; m_id = 0; m_q = 0; m_r = 0; m_ptr = 0;
            m_grants = 0; m_stalls = 0;
        end else begin
            if (exp_w >= 0 && m_grants < 65535) m_grants++;
            if (m_v && !rsp_ready && (|req_valid) && m_stalls < 65535) m_stalls++;
            if (exp_w >= 0) begin
                n = int'(req_numer[exp_w*6 +: 6]);
                m_v = 1; m_id = exp_w; m_q = n / 12; m_r = n % 12;
                m_ptr = (exp_w + 1) % N;
                if (auto_drop) req_valid[exp_w] = 1'b0;
            end else if (m_v && rsp_ready) begin
                m_v = 0;
            end
        end
        exp_w = -1;
    endtask

    int bn[4] = '{0, 63, 23, 12};
    int bq[4] = '{0, 5, 1, 1};
    int br[4] = '{0, 3, 11, 0};

    initial begin
        rst_n = 1'b0; req_valid = '1; req_numer = '0; rsp_ready = 1'b0;
        tick();
        tick();
        eval();
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_q", 32'(rsp_quotient), 32'd0);
        chk("rst_r", 32'(rsp_remain), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);

        // Single request from requester 2
        rst_n = 1'b1; req_valid = 4'b0100; set_numer(2, 45);
        eval();
        chk("single_gnt", 32'(req_ready), 32'h4);
        tick();
        eval();
        chk("single_id", 32'(rsp_id), 32'd2);
        chk("single_q", 32'(rsp_quotient), 32'd3);
        chk("single_r", 32'(rsp_remain), 32'd9);
        chk("single_hold", 32'(req_ready), 32'd0);

        // Arithmetic boundaries
        for (int i = 0; i < 4; i++) begin
            rsp_ready = 1'b1; req_valid = 4'b0001; set_numer(0, bn[i]);
            eval();
            tick();
            eval();
            chk("bound_q", 32'(rsp_quotient), 32'(bq[i]));
            chk("bound_r", 32'(rsp_remain), 32'(br[i]));
        end

        // Reset while FULL
        req_valid = 4'b0010; set_numer(1, 30);
        eval();
        tick();
        rsp_ready = 1'b0; rst_n = 1'b0; req_valid = 4'b1010;
        eval();
        tick();
        eval();
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_id", 32'(rsp_id), 32'd0);
        chk("midrst_q", 32'(rsp_quotient), 32'd0);
        chk("midrst_r", 32'(rsp_remain), 32'd0);
        rst_n = 1'b1;
        eval();
        chk("midrst_first", 32'(req_ready), 32'h2);
        tick();

        // All requesters continuously valid: round-robin order
        rst_n = 1'b0; req_valid = '0;
        tick();
        rst_n = 1'b1; rsp_ready = 1'b1; auto_drop = 0; req_valid = '1;
        for (int i = 0; i < N; i++) set_numer(i, 10*i + 5);
        for (int k = 0; k < 5; k++) begin
            eval();
            chk("rr_gnt", 32'(req_ready), 32'd1 << (k % 4));
            if (k > 0) chk("rr_id", 32'(rsp_id), 32'((k - 1) % 4));
            tick();
        end

        // Backpressure for 5 cycles, then release
        rsp_ready = 1'b0;
        sv_id = m_id; sv_q = m_q; sv_r = m_r;
        for (int k = 0; k < 5; k++) begin
            eval();
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_id", 32'(rsp_id), 32'(sv_id));
            chk("bp_q", 32'(rsp_quotient), 32'(sv_q));
            chk("bp_r", 32'(rsp_remain), 32'(sv_r));
            tick();
        end
        rsp_ready = 1'b1;
        eval();
        chk("bp_release", 32'(req_ready), 32'h2);
        tick();
        eval();
        chk("bp_next_id", 32'(rsp_id), 32'd1);
        tick();

        // Random traffic
        auto_drop = 1; rst_n = 1'b0; req_valid = '0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom % 3 == 0)) begin
                    req_valid[i] = 1'b1;
                    set_numer(i, int'($urandom_range(63, 0)));
                end
            end
            rsp_ready = ($urandom % 4 != 0);
            rst_n = ($urandom % 150 != 0);
            eval();
            tick();
        end
        rst_n = 1'b1;
        eval();

`ifdef DIV12_ARB_STATS_EN
        chk("rand_grants", 32'(stat_grants), 32'(m_grants));
        chk("rand_stalls", 32'(stat_stalls), 32'(m_stalls));
        rst_n = 1'b0; req_valid = '0;
        tick();
        rst_n = 1'b1; rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            req_valid = 4'b0001; set_numer(0, k);
            eval();
            tick();
        end
        rsp_ready = 1'b0; req_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            eval();
            tick();
        end
        chk("stat_grants", 32'(stat_grants), 32'd10);
        chk("stat_stalls", 32'(stat_stalls), 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
